// File: rtl/vga_pattern_gen_module.sv
//==============================================================================
// Module   : vga_pattern_gen_module
// Brief    : RGB565 test-pattern generator (bands, bars, checkerboard, scroll).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module vga_pattern_gen_module #(
    parameter int ADDR_W     = 11,
    parameter int H_ACTIVE   = 800,
    parameter int V_ACTIVE   = 600,
    parameter int BAND_W     = 100,
    parameter int NUM_BANDS  = 4,
    parameter int SCROLL_DIV = 2
) (
    input  logic              vga_clk,
    input  logic              rst_n,
    input  logic              Ready_Sig,
    input  logic [ADDR_W-1:0] Column_Addr_Sig,
    input  logic [ADDR_W-1:0] Row_Addr_Sig,
    input  logic [1:0]        Mode_Sig,
    output logic [4:0]        Red_Sig,
    output logic [5:0]        Green_Sig,
    output logic [4:0]        Blue_Sig,
    output logic              Frame_End_Sig
);

    localparam int C_DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    localparam logic [ADDR_W-1:0]  C_H_ACTIVE  = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0]  C_V_ACTIVE  = ADDR_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0]  C_H_LAST    = ADDR_W'(H_ACTIVE - 1);
    localparam logic [ADDR_W-1:0]  C_V_LAST    = ADDR_W'(V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0]  C_BAND_W    = ADDR_W'(BAND_W);
    localparam logic [ADDR_W-1:0]  C_NUM_BANDS = ADDR_W'(NUM_BANDS);
    localparam logic [ADDR_W:0]    C_BAND_W_X  = (ADDR_W+1)'(BAND_W);
    localparam logic [ADDR_W:0]    C_NB_X      = (ADDR_W+1)'(NUM_BANDS);
    localparam logic [ADDR_W:0]    C_OFS_MAX   = (ADDR_W+1)'(NUM_BANDS * BAND_W - 1);
    localparam logic [C_DIV_W-1:0] C_DIV_MAX   = C_DIV_W'(SCROLL_DIV - 1);

    localparam logic [1:0] C_MODE_HBAND  = 2'd0;
    localparam logic [1:0] C_MODE_VBAR   = 2'd1;
    localparam logic [1:0] C_MODE_CHECK  = 2'd2;
    localparam logic [1:0] C_MODE_SCROLL = 2'd3;

    logic [1:0]         r_mode;
    logic [ADDR_W:0]    r_offset;
    logic [C_DIV_W-1:0] r_div;
    logic [15:0]        r_rgb;
    logic               r_frame_end;

    logic              w_active;
    logic              w_frame_end;
    logic [ADDR_W-1:0] w_row_band;
    logic [ADDR_W-1:0] w_col_band;
    logic [ADDR_W:0]   w_row_sum;
    logic [2:0]        w_scroll_band;
    logic [15:0]       w_rgb;

    // Palette packed as {R[4:0], G[5:0], B[4:0]}.
    function automatic logic [15:0] f_palette(input logic [2:0] idx);
        case (idx)
            3'd0:    f_palette = {5'd31, 6'd63, 5'd31};
            3'd1:    f_palette = {5'd31, 6'd0,  5'd0 };
            3'd2:    f_palette = {5'd0,  6'd63, 5'd0 };
            3'd3:    f_palette = {5'd0,  6'd0,  5'd31};
            3'd4:    f_palette = {5'd31, 6'd63, 5'd0 };
            3'd5:    f_palette = {5'd0,  6'd63, 5'd31};
            3'd6:    f_palette = {5'd31, 6'd0,  5'd31};
            default: f_palette = 16'h0000;
        endcase
    endfunction

    assign w_active    = Ready_Sig && (Column_Addr_Sig < C_H_ACTIVE) && (Row_Addr_Sig < C_V_ACTIVE);
    assign w_frame_end = Ready_Sig && (Column_Addr_Sig == C_H_LAST) && (Row_Addr_Sig == C_V_LAST);

    assign w_row_band    = Row_Addr_Sig / C_BAND_W;
    assign w_col_band    = Column_Addr_Sig / C_BAND_W;
    // One extra bit keeps row + offset from overflowing at the bottom of the frame.
    assign w_row_sum     = {1'b0, Row_Addr_Sig} + r_offset;
    assign w_scroll_band = 3'((w_row_sum / C_BAND_W_X) % C_NB_X);

    always_comb begin
        w_rgb = 16'h0000;
        if (w_active) begin
            case (r_mode)
                C_MODE_HBAND: begin
                    if (w_row_band < C_NUM_BANDS) w_rgb = f_palette(w_row_band[2:0]);
                end
                C_MODE_VBAR: begin
                    if (w_col_band < C_NUM_BANDS) w_rgb = f_palette(w_col_band[2:0]);
                end
                C_MODE_CHECK: begin
                    if ((w_row_band[0] ^ w_col_band[0]) == 1'b0) w_rgb = f_palette(3'd0);
                end
                C_MODE_SCROLL: begin
                    w_rgb = f_palette(w_scroll_band);
                end
                default: w_rgb = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            r_rgb       <= 16'h0000;
            r_frame_end <= 1'b0;
            r_mode      <= 2'd0;
            r_offset    <= '0;
            r_div       <= '0;
        end else begin
            r_rgb       <= w_rgb;
            r_frame_end <= w_frame_end;
            if (w_frame_end) begin
                r_mode <= Mode_Sig;
                if (r_div == C_DIV_MAX) begin
                    r_div    <= '0;
                    r_offset <= (r_offset == C_OFS_MAX) ? '0 : r_offset + 1'b1;
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end
        end
    end

    assign Red_Sig       = r_rgb[15:11];
    assign Green_Sig     = r_rgb[10:5];
    assign Blue_Sig      = r_rgb[4:0];
    assign Frame_End_Sig = r_frame_end;

endmodule

`default_nettype wire

// File: tb/tb_vga_pattern_gen_module.sv
//==============================================================================
// Module   : tb_vga_pattern_gen_module
// Brief    : Directed bench for default and small-geometry pattern generators.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_vga_pattern_gen_module;

    localparam logic [15:0] C_WHITE = 16'hFFFF;
    localparam logic [15:0] C_RED   = 16'hF800;
    localparam logic [15:0] C_GREEN = 16'h07E0;
    localparam logic [15:0] C_BLUE  = 16'h001F;
    localparam logic [15:0] C_BLACK = 16'h0000;

    logic        clk;
    logic        rst_n;

    logic        a_rdy;
    logic [10:0] a_col;
    logic [10:0] a_row;
    logic [1:0]  a_mode;
    logic [4:0]  a_r;
    logic [5:0]  a_g;
    logic [4:0]  a_b;
    logic        a_fe;

    logic        b_rdy;
    logic [10:0] b_col;
    logic [10:0] b_row;
    logic [1:0]  b_mode;
    logic [4:0]  b_r;
    logic [5:0]  b_g;
    logic [4:0]  b_b;
    logic        b_fe;

    int total = 0;
    int bad   = 0;

    vga_pattern_gen_module u_dut_a (
        .vga_clk        (clk),
        .rst_n          (rst_n),
        .Ready_Sig      (a_rdy),
        .Column_Addr_Sig(a_col),
        .Row_Addr_Sig   (a_row),
        .Mode_Sig       (a_mode),
        .Red_Sig        (a_r),
        .Green_Sig      (a_g),
        .Blue_Sig       (a_b),
        .Frame_End_Sig  (a_fe)
    );

    vga_pattern_gen_module #(
        .ADDR_W    (11),
        .H_ACTIVE  (8),
        .V_ACTIVE  (8),
        .BAND_W    (2),
        .NUM_BANDS (4),
        .SCROLL_DIV(2)
    ) u_dut_b (
        .vga_clk        (clk),
        .rst_n          (rst_n),
        .Ready_Sig      (b_rdy),
        .Column_Addr_Sig(b_col),
        .Row_Addr_Sig   (b_row),
        .Mode_Sig       (b_mode),
        .Red_Sig        (b_r),
        .Green_Sig      (b_g),
        .Blue_Sig       (b_b),
        .Frame_End_Sig  (b_fe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pix_a(input logic rdy, input int row, input int col);
        a_rdy = rdy;
        a_row = 11'(row);
        a_col = 11'(col);
        tick();
    endtask

    task automatic pix_b(input logic rdy, input int row, input int col);
        b_rdy = rdy;
        b_row = 11'(row);
        b_col = 11'(col);
        tick();
    endtask

    initial begin
        rst_n  = 1'b0;
        a_rdy  = 1'b0; a_col = '0; a_row = '0; a_mode = 2'd0;
        b_rdy  = 1'b0; b_col = '0; b_row = '0; b_mode = 2'd0;
        tick();
        chk("reset_rgb", {a_r, a_g, a_b}, C_BLACK);
        chk("reset_fe", {15'd0, a_fe}, 16'd0);
        rst_n = 1'b1;

        // Mode 0 bands out of reset
        pix_a(1'b1, 150, 10);  chk("m0_row150", {a_r, a_g, a_b}, C_RED);
        pix_a(1'b1, 350, 10);  chk("m0_row350", {a_r, a_g, a_b}, C_BLUE);
        pix_a(1'b1, 450, 10);  chk("m0_row450", {a_r, a_g, a_b}, C_BLACK);
        pix_a(1'b1, 0, 799);   chk("m0_row0", {a_r, a_g, a_b}, C_WHITE);

        // Blanking
        pix_a(1'b0, 50, 10);   chk("blank_rdy", {a_r, a_g, a_b}, C_BLACK);
        pix_a(1'b1, 50, 800);  chk("blank_col", {a_r, a_g, a_b}, C_BLACK);
        pix_a(1'b1, 600, 10);  chk("blank_row", {a_r, a_g, a_b}, C_BLACK);
        pix_a(1'b1, 150, 10);
        rst_n = 1'b0;
        pix_a(1'b1, 599, 799);
        chk("midrst_rgb", {a_r, a_g, a_b}, C_BLACK);
        chk("midrst_fe", {15'd0, a_fe}, 16'd0);
        rst_n = 1'b1;

        // Mode latch: request mode 1 mid-frame, still mode 0 until frame end
        a_mode = 2'd1;
        pix_a(1'b1, 150, 250); chk("latch_hold", {a_r, a_g, a_b}, C_RED);
        pix_a(1'b1, 599, 799);
        chk("fe_pix_rgb", {a_r, a_g, a_b}, C_BLACK);
        chk("fe_pulse", {15'd0, a_fe}, 16'd1);
        pix_a(1'b1, 0, 250);
        chk("m1_col250", {a_r, a_g, a_b}, C_GREEN);
        chk("fe_low", {15'd0, a_fe}, 16'd0);
        pix_a(1'b1, 0, 50);    chk("m1_col50", {a_r, a_g, a_b}, C_WHITE);

        // Ready low at the last pixel address is not a frame end
        a_mode = 2'd2;
        pix_a(1'b0, 599, 799);
        chk("nofe_rdy0", {15'd0, a_fe}, 16'd0);
        pix_a(1'b1, 50, 150);  chk("m1_still", {a_r, a_g, a_b}, C_RED);

        // Checkerboard
        pix_a(1'b1, 599, 799);
        pix_a(1'b1, 50, 50);   chk("chk_50_50", {a_r, a_g, a_b}, C_WHITE);
        pix_a(1'b1, 50, 150);  chk("chk_50_150", {a_r, a_g, a_b}, C_BLACK);
        pix_a(1'b1, 150, 150); chk("chk_150_150", {a_r, a_g, a_b}, C_WHITE);
        pix_a(1'b1, 599, 0);   chk("chk_599_0", {a_r, a_g, a_b}, C_BLACK);
        a_rdy = 1'b0;

        // Scrolling on small geometry: frame end 1 latches mode 3
        b_mode = 2'd3;
        pix_b(1'b1, 7, 7);
        chk("b_fe1_rgb", {b_r, b_g, b_b}, C_BLUE);
        chk("b_fe1_pulse", {15'd0, b_fe}, 16'd1);
        pix_b(1'b1, 1, 0);     chk("b_ofs0_row1", {b_r, b_g, b_b}, C_WHITE);
        pix_b(1'b1, 7, 7);
        pix_b(1'b1, 1, 0);     chk("b_ofs1_row1", {b_r, b_g, b_b}, C_RED);
        pix_b(1'b1, 8, 0);     chk("b_blank_row", {b_r, b_g, b_b}, C_BLACK);
        for (int i = 0; i < 3; i++) pix_b(1'b0, 7, 7);
        chk("b_rdy0_nofe", {15'd0, b_fe}, 16'd0);
        pix_b(1'b1, 1, 0);     chk("b_rdy0_hold", {b_r, b_g, b_b}, C_RED);
        for (int i = 0; i < 4; i++) pix_b(1'b1, 7, 7);
        pix_b(1'b1, 1, 0);     chk("b_ofs3_row1", {b_r, b_g, b_b}, C_GREEN);
        pix_b(1'b1, 7, 3);     chk("b_ofs3_row7", {b_r, b_g, b_b}, C_RED);
        for (int i = 0; i < 10; i++) pix_b(1'b1, 7, 7);
        pix_b(1'b1, 1, 0);     chk("b_wrap_row1", {b_r, b_g, b_b}, C_WHITE);
        pix_b(1'b1, 7, 0);     chk("b_wrap_row7", {b_r, b_g, b_b}, C_BLUE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_pattern_gen_module.md
Name: vga_pattern_gen_module

Overview:
- Parametrised VGA test-pattern generator.
- Sits between the sync/timing module (which supplies Ready_Sig and the column/row addresses) and the RGB565 pin driver.
- Generalises the fixed four-band colour display to: configurable band size and count, four selectable patterns, a frame-synchronous mode latch, and a scrolling mode driven by a frame counter.

Parameters:
- ADDR_W, 11, width of column/row address inputs.
- H_ACTIVE, 800, active columns per line.
- V_ACTIVE, 600, active rows per frame.
- BAND_W, 100, band/bar/checker cell size in pixels (>=1).
- NUM_BANDS, 4, number of palette bands used (1..8).
- SCROLL_DIV, 2, frames per 1-pixel scroll step (>=1).

Ports:
- vga_clk, in, 1, pixel clock; all logic on its rising edge.
- rst_n, in, 1, synchronous active-low reset.
- Ready_Sig, in, 1, high while the addresses denote an active pixel.
- Column_Addr_Sig, in, ADDR_W, current column.
- Row_Addr_Sig, in, ADDR_W, current row.
- Mode_Sig, in, 2, requested pattern: 0 horizontal bands, 1 vertical bars, 2 checkerboard, 3 scrolling horizontal bands.
- Red_Sig, out, 5, red level.
- Green_Sig, out, 6, green level.
- Blue_Sig, out, 5, blue level.
- Frame_End_Sig, out, 1, one-cycle pulse registered with the last active pixel's colour.

Behaviour:
- **Clocking and reset**
  - Single clock. Reset is sampled only on a vga_clk edge with rst_n=0.
  - Reset values: Red/Green/Blue = 0, Frame_End_Sig = 0, latched mode = 0, scroll offset = 0, frame divider = 0.
  - Reset asserted mid-frame: outputs go black on that edge. The next frame after release starts in mode 0 with offset 0.
- **Latency**
  - Colour outputs are registered, exactly 1 cycle after the address/Ready sample.
- **Palette (band index 0..7)**
  - 0 white (31,63,31), 1 red (31,0,0), 2 green (0,63,0), 3 blue (0,0,31).
  - 4 yellow (31,63,0), 5 cyan (0,63,31), 6 magenta (31,0,31), 7 black.
- **Blanking**
  - Output is black if Ready_Sig=0, or Column >= H_ACTIVE, or Row >= V_ACTIVE.
  - Blanking has priority over all modes.
- **Mode 0**
  - b = Row / BAND_W.
  - Palette[b] if b < NUM_BANDS, else black.
- **Mode 1**
  - Same as mode 0 with b = Column / BAND_W.
- **Mode 2**
  - c = (Row / BAND_W) XOR (Column / BAND_W).
  - c bit0 = 0 gives white; c bit0 = 1 gives black.
- **Mode 3**
  - b = ((Row + offset) / BAND_W) mod NUM_BANDS. Always coloured, never black from band overflow.
- **Frame end event**
  - Occurs when Ready_Sig=1, Column = H_ACTIVE-1 and Row = V_ACTIVE-1.
  - On that edge:
    - Mode_Sig is latched as the mode for the next frame.
    - Frame_End_Sig is registered high for 1 cycle.
    - The frame divider increments.
  - When the divider reaches SCROLL_DIV-1 it wraps to 0, and offset increments.
  - Offset wraps from NUM_BANDS*BAND_W-1 to 0.
  - Offset and divider advance in every mode; only mode 3 displays them.
- **Mode_Sig changes**
  - Changes mid-frame have no visible effect until after the next frame end.
- **Ready_Sig low**
  - Holds mode, offset and divider. Only frame end events change them.
- **Arithmetic**
  - Row + offset is computed at ADDR_W+1 bits; no overflow is allowed.
  - Division/modulo by BAND_W may be implemented with band counters in place of dividers, provided results match the formulas for every pixel.

Test Plan:
1. Defaults, mode 0 (reset value): Ready=1, row 150, col 10 -> next cycle (31,0,0); row 350 -> (0,0,31); row 450 -> (0,0,0) since band 4 >= NUM_BANDS.
2. Blanking: row 50 with Ready=0 -> (0,0,0); col 800 with Ready=1 -> (0,0,0); rst_n=0 for one edge mid-frame -> outputs 0 and Frame_End_Sig=0 on that edge.
3. Mode latch: drive Mode_Sig=1 mid-frame -> pattern unchanged (still mode 0) until the frame end pixel (799,599); Frame_End_Sig pulses one cycle; next frame col 250 -> (0,63,0).
4. Checkerboard: mode 2 latched, pixel (row 50, col 50) -> white; (row 50, col 150) -> black; (row 150, col 150) -> white.
5. Scroll/wrap with H_ACTIVE=8, V_ACTIVE=8, BAND_W=2, NUM_BANDS=4, SCROLL_DIV=2, mode 3:
   - After 2 frame ends (offset 1): row 1 -> red.
   - After 16 frame ends: offset wraps to 0 and row 1 -> white.
   - Toggling Ready low between frames does not advance offset.
